// File: rtl/sym_pkg.sv
// Shared types and constants for the 2-bit symbol packer.
package sym_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      PACK = 1'b1
   } state_e;

   localparam int unsigned SYMS_PER_BYTE = 4;
   localparam int unsigned FIFO_DEPTH    = 2;

endpackage

// File: rtl/sym_fifo2.sv
// Two-entry 8-bit output buffer; a push into a full buffer is accepted only when
// a pop frees the head slot on the same edge.
module sym_fifo2
   import sym_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);

   logic [7:0] mem_q [FIFO_DEPTH];
   logic [7:0] mem_d [FIFO_DEPTH];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] cnt_q, cnt_d;
   logic       do_push, do_pop;

   always_comb begin
      do_pop   = pop & (cnt_q != 2'd0);
      do_push  = push & ((cnt_q != 2'(FIFO_DEPTH)) | do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q    <= '{default: 8'h00};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign empty = (cnt_q == 2'd0);
   assign full  = (cnt_q == 2'(FIFO_DEPTH));
   // Head reads as zero while empty so out_data is clean between bytes.
   assign rdata = empty ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: rtl/sym_packer.sv
// Hunts a 2-bit symbol stream for a sync word, then packs FRAME_LEN payload bytes
// MSB-first into a 2-entry output buffer. Optional byte statistic: SYM_PACKER_STATS_EN.
module sym_packer
   import sym_pkg::*;
#(
   parameter logic [7:0]  SYNC_WORD = 8'hA5,
   parameter int unsigned FRAME_LEN = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sym_en,
   input  logic [1:0]  sym_in,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        sync_lock,
   output logic        ovf,
   output logic [15:0] byte_cnt
);

   localparam logic [1:0] LAST_SYM  = 2'(SYMS_PER_BYTE - 1);
   localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);

   if (FRAME_LEN < 1 || FRAME_LEN > 255) begin : g_bad_len
      $error("sym_packer: FRAME_LEN must be in 1..255");
   end

   state_e     state_q, state_d;
   logic [7:0] win_q, win_d;
   logic [5:0] shift_q, shift_d;
   logic [1:0] sym_cnt_q, sym_cnt_d;
   logic [7:0] frm_cnt_q, frm_cnt_d;
   logic       ovf_q, ovf_d;

   logic       push;
   logic [7:0] push_data;
   logic       pop;
   logic       fifo_full;
   logic       fifo_empty;

   assign out_valid = ~fifo_empty;
   assign pop       = out_valid & out_ready;
   assign push_data = {shift_q, sym_in};

   always_comb begin
      state_d   = state_q;
      win_d     = win_q;
      shift_d   = shift_q;
      sym_cnt_d = sym_cnt_q;
      frm_cnt_d = frm_cnt_q;
      ovf_d     = ovf_q;
      push      = 1'b0;
      if (sym_en) begin
         case (state_q)
            HUNT: begin
               win_d = {win_q[5:0], sym_in};
               if (win_d == SYNC_WORD) begin
                  state_d   = PACK;
                  shift_d   = 6'd0;
                  sym_cnt_d = 2'd0;
                  frm_cnt_d = 8'd0;
               end
            end
            PACK: begin
               shift_d = {shift_q[3:0], sym_in};
               if (sym_cnt_q == LAST_SYM) begin
                  sym_cnt_d = 2'd0;
                  shift_d   = 6'd0;
                  // A same-edge pop frees the head slot, so the byte still fits.
                  if (fifo_full && !pop) begin
                     ovf_d = 1'b1;
                  end else begin
                     push = 1'b1;
                  end
                  if (frm_cnt_q == LAST_BYTE) begin
                     state_d   = HUNT;
                     win_d     = 8'd0;
                     frm_cnt_d = 8'd0;
                  end else begin
                     frm_cnt_d = frm_cnt_q + 8'd1;
                  end
               end else begin
                  sym_cnt_d = sym_cnt_q + 2'd1;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= HUNT;
         win_q     <= 8'd0;
         shift_q   <= 6'd0;
         sym_cnt_q <= 2'd0;
         frm_cnt_q <= 8'd0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         win_q     <= win_d;
         shift_q   <= shift_d;
         sym_cnt_q <= sym_cnt_d;
         frm_cnt_q <= frm_cnt_d;
         ovf_q     <= ovf_d;
      end
   end

   assign sync_lock = (state_q == PACK);
   assign ovf       = ovf_q;

   sym_fifo2 u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (push_data),
      .pop   (pop),
      .rdata (out_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef SYM_PACKER_STATS_EN
   logic [15:0] stat_q, stat_d;

   always_comb begin
      stat_d = stat_q;
      if (pop && (stat_q != 16'hFFFF)) begin
         stat_d = stat_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_q <= 16'd0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign byte_cnt = stat_q;
`else
   assign byte_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sym_packer.sv
// Bench for sym_packer: two instances (FRAME_LEN 2 and 16) share one stimulus stream.
module tb_sym_packer;

   localparam logic [7:0] SYNC = 8'hA5;
`ifdef SYM_PACKER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        sym_en;
   logic [1:0]  sym_in;
   logic        out_ready;
   logic [7:0]  o_data  [2];
   logic        o_valid [2];
   logic        o_lock  [2];
   logic        o_ovf   [2];
   logic [15:0] o_cnt   [2];

   always #5 clk = ~clk;

   sym_packer #(.SYNC_WORD(SYNC), .FRAME_LEN(2)) dut_a (
      .clk       (clk),
      .reset     (reset),
      .sym_en    (sym_en),
      .sym_in    (sym_in),
      .out_data  (o_data[0]),
      .out_valid (o_valid[0]),
      .out_ready (out_ready),
      .sync_lock (o_lock[0]),
      .ovf       (o_ovf[0]),
      .byte_cnt  (o_cnt[0])
   );

   sym_packer #(.SYNC_WORD(SYNC), .FRAME_LEN(16)) dut_b (
      .clk       (clk),
      .reset     (reset),
      .sym_en    (sym_en),
      .sym_in    (sym_in),
      .out_data  (o_data[1]),
      .out_valid (o_valid[1]),
      .out_ready (out_ready),
      .sync_lock (o_lock[1]),
      .ovf       (o_ovf[1]),
      .byte_cnt  (o_cnt[1])
   );

   int checks = 0;
   int failures = 0;

   // Reference model: frame-level behaviour with queues and integer arithmetic.
   int         fl [2] = '{2, 16};
   logic [7:0] fifo_a [$];
   logic [7:0] fifo_b [$];
   bit         m_lock [2];
   int         m_win [2];
   int         m_acc [2];
   int         m_nsym [2];
   int         m_nbyte [2];
   bit         m_ovf [2];
   int         m_cnt [2];

   task automatic model_reset();
      fifo_a.delete();
      fifo_b.delete();
      for (int k = 0; k < 2; k++) begin
         m_lock[k] = 0; m_win[k] = 0; m_acc[k] = 0; m_nsym[k] = 0;
         m_nbyte[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0;
      end
   endtask

   task automatic model_step(input int k, input bit en, input int s, input bit rdy);
      logic [7:0] q [$];
      bit         pop;
      bit         push;
      logic [7:0] b;
      push = 0;
      b = 8'h00;
      if (k == 0) q = fifo_a; else q = fifo_b;
      pop = rdy && (q.size() > 0);
      if (en) begin
         if (!m_lock[k]) begin
            m_win[k] = (m_win[k] * 4 + s) % 256;
            if (m_win[k] == int'(SYNC)) begin
               m_lock[k] = 1; m_acc[k] = 0; m_nsym[k] = 0; m_nbyte[k] = 0;
            end
         end else begin
            m_acc[k] = m_acc[k] * 4 + s;
            m_nsym[k]++;
            if (m_nsym[k] == 4) begin
               b = 8'(m_acc[k]);
               m_acc[k] = 0;
               m_nsym[k] = 0;
               if (q.size() == 2 && !pop) m_ovf[k] = 1;
               else push = 1;
               m_nbyte[k]++;
               if (m_nbyte[k] == fl[k]) begin
                  m_lock[k] = 0;
                  m_win[k] = 0;
               end
            end
         end
      end
      if (pop) begin
         void'(q.pop_front());
         if (m_cnt[k] < 65535) m_cnt[k]++;
      end
      if (push) q.push_back(b);
      if (k == 0) fifo_a = q; else fifo_b = q;
   endtask

   function automatic int exp_size(input int k);
      return (k == 0) ? fifo_a.size() : fifo_b.size();
   endfunction

   function automatic logic [7:0] exp_data(input int k);
      if (k == 0) return (fifo_a.size() > 0) ? fifo_a[0] : 8'h00;
      return (fifo_b.size() > 0) ? fifo_b[0] : 8'h00;
   endfunction

   task automatic step(input bit en, input int s, input bit rdy);
      sym_en    = en;
      sym_in    = 2'(s);
      out_ready = rdy;
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k, en, s, rdy);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      sym_en    = 1'b1;
      sym_in    = 2'($urandom_range(0, 3));
      out_ready = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      reset = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v, input bit rdy);
      logic [7:0] t;
      t = v;
      step(1, int'(t[7:6]), rdy);
      step(1, int'(t[5:4]), rdy);
      step(1, int'(t[3:2]), rdy);
      step(1, int'(t[1:0]), rdy);
   endtask

   task automatic test_reset();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (o_valid[k] !== 1'b0 || o_data[k] !== 8'h00 || o_lock[k] !== 1'b0 ||
             o_ovf[k] !== 1'b0 || o_cnt[k] !== 16'h0000) begin
            failures++;
            $display("FAIL reset_outputs dut%0d got v=%b d=%h l=%b o=%b c=%0d exp all 0",
                     k, o_valid[k], o_data[k], o_lock[k], o_ovf[k], o_cnt[k]);
         end
      end
   endtask

   task automatic test_lock_pack();
      do_reset();
      step(1, 2, 1); step(1, 2, 1); step(1, 1, 1);
      checks++;
      if (o_lock[1] !== 1'b0) begin
         failures++; $display("FAIL early_lock got=%b exp=0", o_lock[1]);
      end
      step(1, 1, 1);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (o_lock[k] !== 1'b1) begin
            failures++; $display("FAIL lock dut%0d got=%b exp=1", k, o_lock[k]);
         end
      end
      step(1, 0, 1); step(1, 3, 1); step(1, 3, 1); step(1, 0, 1);
      checks++;
      if (o_valid[1] !== 1'b1 || o_data[1] !== 8'h3C) begin
         failures++;
         $display("FAIL first_byte got v=%b d=%h exp v=1 d=3c", o_valid[1], o_data[1]);
      end
      step(1, 1, 1); step(1, 2, 1); step(1, 3, 1); step(1, 0, 1);
      checks++;
      if (o_lock[0] !== 1'b0 || o_data[0] !== 8'h6C || o_valid[0] !== 1'b1) begin
         failures++;
         $display("FAIL frame_end got l=%b v=%b d=%h exp l=0 v=1 d=6c",
                  o_lock[0], o_valid[0], o_data[0]);
      end
      checks++;
      if (o_lock[1] !== 1'b1) begin
         failures++; $display("FAIL long_frame_lock got=%b exp=1", o_lock[1]);
      end
      step(1, 2, 1); step(1, 2, 1); step(1, 1, 1); step(1, 1, 1);
      checks++;
      if (o_lock[0] !== 1'b1) begin
         failures++; $display("FAIL relock got=%b exp=1", o_lock[0]);
      end
      checks++;
      if (o_data[1] !== 8'hA5 || o_valid[1] !== 1'b1 || o_lock[1] !== 1'b1) begin
         failures++;
         $display("FAIL sync_as_payload got v=%b d=%h l=%b exp v=1 d=a5 l=1",
                  o_valid[1], o_data[1], o_lock[1]);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      step(1, 2, 0); step(1, 2, 0); step(1, 1, 0); step(1, 1, 0);
      send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0);
      checks++;
      if (o_ovf[1] !== 1'b1 || o_valid[1] !== 1'b1 || o_data[1] !== 8'h12) begin
         failures++;
         $display("FAIL ovf_set got o=%b v=%b d=%h exp o=1 v=1 d=12",
                  o_ovf[1], o_valid[1], o_data[1]);
      end
      checks++;
      if (o_ovf[0] !== 1'b0) begin
         failures++; $display("FAIL short_frame_ovf got=%b exp=0", o_ovf[0]);
      end
      step(0, 0, 1);
      checks++;
      if (o_data[1] !== 8'h34 || o_valid[1] !== 1'b1) begin
         failures++;
         $display("FAIL ovf_second got v=%b d=%h exp v=1 d=34", o_valid[1], o_data[1]);
      end
      step(0, 0, 1);
      checks++;
      if (o_valid[1] !== 1'b0 || o_ovf[1] !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky got v=%b o=%b exp v=0 o=1", o_valid[1], o_ovf[1]);
      end
   endtask

   task automatic test_full_pop();
      do_reset();
      step(1, 2, 0); step(1, 2, 0); step(1, 1, 0); step(1, 1, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0);
      step(1, 0, 0); step(1, 3, 0); step(1, 0, 0); step(1, 3, 1);
      checks++;
      if (o_ovf[1] !== 1'b0 || o_data[1] !== 8'h22 || o_valid[1] !== 1'b1) begin
         failures++;
         $display("FAIL full_pop got o=%b v=%b d=%h exp o=0 v=1 d=22",
                  o_ovf[1], o_valid[1], o_data[1]);
      end
      step(0, 0, 1);
      checks++;
      if (o_data[1] !== 8'h33 || o_valid[1] !== 1'b1) begin
         failures++;
         $display("FAIL full_pop_third got v=%b d=%h exp v=1 d=33", o_valid[1], o_data[1]);
      end
      step(0, 0, 1);
      checks++;
      if (o_valid[1] !== 1'b0 || o_ovf[1] !== 1'b0) begin
         failures++;
         $display("FAIL full_pop_drain got v=%b o=%b exp v=0 o=0", o_valid[1], o_ovf[1]);
      end
   endtask

   task automatic test_reset_mid_and_gaps();
      do_reset();
      step(1, 2, 0); step(1, 2, 0); step(1, 1, 0); step(1, 1, 0);
      send_byte(8'h12, 0);
      step(1, 3, 0); step(1, 1, 0);
      do_reset();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (o_valid[k] !== 1'b0 || o_data[k] !== 8'h00 || o_lock[k] !== 1'b0 ||
             o_ovf[k] !== 1'b0 || o_cnt[k] !== 16'h0000) begin
            failures++;
            $display("FAIL mid_reset dut%0d got v=%b d=%h l=%b o=%b c=%0d exp all 0",
                     k, o_valid[k], o_data[k], o_lock[k], o_ovf[k], o_cnt[k]);
         end
      end
      step(1, 2, 0); step(1, 2, 0); step(1, 1, 0); step(1, 1, 0);
      step(1, 2, 0); step(0, 3, 0); step(0, 1, 0);
      step(1, 1, 0); step(0, 2, 0);
      step(1, 3, 0); step(0, 3, 0); step(0, 0, 0);
      step(1, 0, 0);
      checks++;
      if (o_data[1] !== 8'h9C || o_valid[1] !== 1'b1 || o_lock[1] !== 1'b1) begin
         failures++;
         $display("FAIL gap_pack got v=%b d=%h l=%b exp v=1 d=9c l=1",
                  o_valid[1], o_data[1], o_lock[1]);
      end
   endtask

   task automatic test_stats();
      do_reset();
      step(1, 2, 1); step(1, 2, 1); step(1, 1, 1); step(1, 1, 1);
      for (int i = 0; i < 5; i++) send_byte(8'h01, 1);
      step(0, 0, 1); step(0, 0, 1);
      checks++;
      if (o_cnt[1] !== (STATS ? 16'd5 : 16'd0)) begin
         failures++;
         $display("FAIL stats_five got=%0d exp=%0d", o_cnt[1], STATS ? 5 : 0);
      end
      checks++;
      if (o_cnt[0] !== (STATS ? 16'd2 : 16'd0)) begin
         failures++;
         $display("FAIL stats_short got=%0d exp=%0d", o_cnt[0], STATS ? 2 : 0);
      end
   endtask

   task automatic test_random();
      int inject;
      inject = 0;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else if (inject > 0) begin
            step(1, (inject == 4 || inject == 3) ? 2 : 1, $urandom_range(0, 1) == 1);
            inject--;
         end else begin
            if ($urandom_range(0, 39) == 0) inject = 4;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
         end
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_valid[k] !== (exp_size(k) > 0) || o_data[k] !== exp_data(k) ||
                o_lock[k] !== m_lock[k] || o_ovf[k] !== m_ovf[k] ||
                o_cnt[k] !== (STATS ? 16'(m_cnt[k]) : 16'd0)) begin
               failures++;
               $display("FAIL random dut%0d cyc%0d got v=%b d=%h l=%b o=%b c=%0d exp v=%b d=%h l=%b o=%b c=%0d",
                        k, cyc, o_valid[k], o_data[k], o_lock[k], o_ovf[k], o_cnt[k],
                        exp_size(k) > 0, exp_data(k), m_lock[k], m_ovf[k],
                        STATS ? m_cnt[k] : 0);
            end
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      sym_en    = 1'b0;
      sym_in    = 2'd0;
      out_ready = 1'b0;
      model_reset();
      test_reset();
      test_lock_pack();
      test_overflow();
      test_full_pop();
      test_reset_mid_and_gaps();
      test_stats();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
